// File: rtl/keyb_pkg.sv
// Purpose: shared key codes, ASCII constants and output FSM states for key_seq_buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a. The escape states exist only when KEYB_ESC_EXPAND_EN is defined.
package keyb_pkg;

  localparam logic [7:0] KEY_UP     = 8'h80;
  localparam logic [7:0] KEY_DOWN   = 8'h81;
  localparam logic [7:0] KEY_RIGHT  = 8'h82;
  localparam logic [7:0] KEY_LEFT   = 8'h83;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;
  localparam logic [7:0] ASCII_LBRK = 8'h5B;

`ifdef KEYB_ESC_EXPAND_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT    = 2'd1,
    ESC_BRK = 2'd2,
    ESC_FIN = 2'd3
  } state_t;

  // Arrow keys occupy 0x80..0x83, so only the two low bits vary.
  function automatic logic is_arrow(input logic [7:0] key);
    return (key[7:2] == KEY_UP[7:2]);
  endfunction

  // Final letter of the arrow sequence: 'A'..'D' in key order.
  function automatic logic [7:0] arrow_letter(input logic [7:0] key);
    return 8'h41 + {6'd0, key[1:0]};
  endfunction
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/key_fifo.sv
// Purpose: synchronous key FIFO with pointers one bit wider than the address (wrap mod 2*DEPTH).
// Latency: a push at edge N is visible on rdata/empty right after edge N; rdata is combinational.
// Backpressure: a push while full and a pop while empty are ignored. There is no bypass when full.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);
  import keyb_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign fill  = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  // Storage array: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update: natural binary wrap gives the modulo 2*DEPTH behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/key_seq_buffer.sv
// Purpose: buffers mapped key codes and streams them as bytes. With KEYB_ESC_EXPAND_EN, arrows become ESC '[' letter.
// Latency: a key accepted at edge N into an idle, empty block gives o_byte_valid high after edge N+1. One byte per cycle.
// Backpressure: valid/ready on both sides. o_key_ready = !full (held 0 until the first edge after reset), and o_byte holds while stalled.
module key_seq_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_key,
  input  logic                     i_key_valid,
  output logic                     o_key_ready,
  output logic [7:0]               o_byte,
  input  logic                     i_byte_ready,
  output logic                     o_byte_valid,
  output logic [$clog2(DEPTH):0]   o_fill
);
  import keyb_pkg::*;

  logic       rdy_en;
  logic       push;
  logic       pop;
  logic       take;
  logic       xfer;
  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;

  state_t     state_q, state_d;
  logic [7:0] byte_q, byte_d;
`ifdef KEYB_ESC_EXPAND_EN
  logic [7:0] letter_q, letter_d;
  logic       exp_q, exp_d;
`endif

  assign o_key_ready  = rdy_en && !fifo_full;
  assign push         = i_key_valid && o_key_ready;
  assign o_byte_valid = (state_q != IDLE);
  assign o_byte       = byte_q;
  assign xfer         = o_byte_valid && i_byte_ready;

  key_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata (i_key),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (o_fill)
  );

  // Input ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // Output FSM next state: decide whether to pop a fresh key or step through the escape sequence.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    take    = 1'b0;
`ifdef KEYB_ESC_EXPAND_EN
    letter_d = letter_q;
    exp_d    = exp_q;
`endif
    case (state_q)
      IDLE: take = !fifo_empty;
      EMIT: begin
        if (xfer) begin
`ifdef KEYB_ESC_EXPAND_EN
          if (exp_q) begin
            state_d = ESC_BRK;
            byte_d  = ASCII_LBRK;
            exp_d   = 1'b0;
          end else begin
            take = !fifo_empty;
            if (fifo_empty) state_d = IDLE;
          end
`else
          take = !fifo_empty;
          if (fifo_empty) state_d = IDLE;
`endif
        end
      end
`ifdef KEYB_ESC_EXPAND_EN
      ESC_BRK: begin
        if (xfer) begin
          state_d = ESC_FIN;
          byte_d  = letter_q;
        end
      end
      ESC_FIN: begin
        if (xfer) begin
          take = !fifo_empty;
          if (fifo_empty) state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = EMIT;
`ifdef KEYB_ESC_EXPAND_EN
      if (is_arrow(fifo_rdata)) begin
        byte_d   = ASCII_ESC;
        letter_d = arrow_letter(fifo_rdata);
        exp_d    = 1'b1;
      end else begin
        byte_d = fifo_rdata;
        exp_d  = 1'b0;
      end
`else
      byte_d = fifo_rdata;
`endif
    end
  end

  assign pop = take;

  // Output FSM registers. Reset drops any partial escape sequence.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      byte_q  <= 8'h00;
`ifdef KEYB_ESC_EXPAND_EN
      letter_q <= 8'h00;
      exp_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
`ifdef KEYB_ESC_EXPAND_EN
      letter_q <= letter_d;
      exp_q    <= exp_d;
`endif
    end
  end

endmodule

// File: tb/tb_key_seq_buffer.sv
module tb_key_seq_buffer;
  localparam int DEPTH = 8;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n = 1'b0;
  logic [7:0]             i_key = 8'h00;
  logic                   i_key_valid = 1'b0;
  logic                   o_key_ready;
  logic [7:0]             o_byte;
  logic                   i_byte_ready = 1'b0;
  logic                   o_byte_valid;
  logic [$clog2(DEPTH):0] o_fill;

  key_seq_buffer #(.DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_key        (i_key),
    .i_key_valid  (i_key_valid),
    .o_key_ready  (o_key_ready),
    .o_byte       (o_byte),
    .i_byte_ready (i_byte_ready),
    .o_byte_valid (o_byte_valid),
    .o_fill       (o_fill)
  );

  always #5 i_clk = ~i_clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         xfer_cnt = 0;
  int         xcyc[$];
  logic [7:0] sb[$];
  logic [7:0] mon_exp;

  always @(posedge i_clk) cyc++;

  // Scoreboard monitor: a transfer happens at the next rising edge when valid && ready at the falling edge.
  always @(negedge i_clk) begin
    if (i_rst_n && o_byte_valid && i_byte_ready) begin
      xfer_cnt++;
      xcyc.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_byte: got %h, expected nothing", o_byte);
      end else begin
        mon_exp = sb.pop_front();
        if (o_byte !== mon_exp) begin
          n_err++;
          $display("FAIL byte_order: got %h, expected %h", o_byte, mon_exp);
        end
      end
    end
  end

  // Reference model for the byte stream produced by one key.
  task automatic expect_key(input logic [7:0] k);
`ifdef KEYB_ESC_EXPAND_EN
    if (k >= 8'h80 && k <= 8'h83) begin
      sb.push_back(8'h1B);
      sb.push_back(8'h5B);
      sb.push_back(8'h41 + (k - 8'h80));
    end else begin
      sb.push_back(k);
    end
`else
    sb.push_back(k);
`endif
  endtask

  function automatic int exp_len(input logic [7:0] k);
`ifdef KEYB_ESC_EXPAND_EN
    if (k >= 8'h80 && k <= 8'h83) return 3;
`endif
    return 1;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Offer a key for one cycle. Returns whether it was accepted.
  task automatic offer(input logic [7:0] k, output bit acc);
    i_key       = k;
    i_key_valid = 1'b1;
    @(negedge i_clk);
    acc = o_key_ready;
    if (acc) expect_key(k);
    step();
    i_key_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && (sb.size() != 0 || o_byte_valid); i++) step();
    n_cmp++;
    if (sb.size() != 0 || o_byte_valid) begin
      n_err++;
      $display("FAIL %s_drain: pending=%0d valid=%b, expected pending=0 valid=0", name, sb.size(), o_byte_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (o_byte_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, expected 0", o_byte_valid); end
    n_cmp++;
    if (o_fill !== '0) begin n_err++; $display("FAIL rst_fill: got %0d, expected 0", o_fill); end
    n_cmp++;
    if (o_byte !== 8'h00) begin n_err++; $display("FAIL rst_byte: got %h, expected 00", o_byte); end
    step();
    step();
    n_cmp++;
    if (o_key_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b, expected 0", o_key_ready); end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if (o_key_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b, expected 0", o_key_ready); end
    step();
    n_cmp++;
    if (o_key_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b, expected 1", o_key_ready); end
  endtask

  task automatic test_single();
    int x0;
    bit acc;
    i_byte_ready = 1'b1;
    x0 = xfer_cnt;
    offer(8'h61, acc);
    n_cmp++;
    if (o_byte_valid !== 1'b0) begin n_err++; $display("FAIL single_early: valid=%b after edge N, expected 0", o_byte_valid); end
    step();
    n_cmp++;
    if (o_byte_valid !== 1'b1 || o_byte !== 8'h61) begin
      n_err++; $display("FAIL single_latency: valid=%b byte=%h after edge N+1, expected 1/61", o_byte_valid, o_byte);
    end
    wait_drain("single");
    n_cmp++;
    if (xfer_cnt - x0 !== 1) begin n_err++; $display("FAIL single_count: got %0d bytes, expected 1", xfer_cnt - x0); end
  endtask

  task automatic test_escape(input logic [7:0] k);
    int x0;
    int n;
    bit acc;
    i_byte_ready = 1'b1;
    x0 = xfer_cnt;
    n = exp_len(k);
    offer(k, acc);
    wait_drain("escape");
    n_cmp++;
    if (xfer_cnt - x0 !== n) begin
      n_err++; $display("FAIL escape_count_%h: got %0d bytes, expected %0d", k, xfer_cnt - x0, n);
    end else begin
      n_cmp++;
      if (xcyc[$] - xcyc[xcyc.size() - n] !== n - 1) begin
        n_err++; $display("FAIL escape_rate_%h: span %0d cycles, expected %0d", k, xcyc[$] - xcyc[xcyc.size() - n], n - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int x0;
    int acc_n;
    bit acc;
    i_byte_ready = 1'b0;
    x0 = xfer_cnt;
    acc_n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      offer(8'h10 + 8'(i), acc);
      if (acc) acc_n++;
      if (i >= 1) begin
        n_cmp++;
        if (o_byte_valid !== 1'b1 || o_byte !== 8'h10) begin
          n_err++; $display("FAIL bp_hold_%0d: valid=%b byte=%h, expected 1/10", i, o_byte_valid, o_byte);
        end
      end
    end
    n_cmp++;
    if (acc_n !== DEPTH + 1) begin n_err++; $display("FAIL bp_accepted: got %0d, expected %0d", acc_n, DEPTH + 1); end
    n_cmp++;
    if (o_fill !== DEPTH) begin n_err++; $display("FAIL bp_fill: got %0d, expected %0d", o_fill, DEPTH); end
    n_cmp++;
    if (o_key_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b, expected 0", o_key_ready); end
    i_byte_ready = 1'b1;
    wait_drain("bp");
    n_cmp++;
    if (xfer_cnt - x0 !== DEPTH + 1) begin n_err++; $display("FAIL bp_count: got %0d, expected %0d", xfer_cnt - x0, DEPTH + 1); end
  endtask

  task automatic test_back_to_back();
    int x0;
    i_byte_ready = 1'b1;
    x0 = xfer_cnt;
    i_key_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      i_key = 8'h20 + 8'(i);
      @(negedge i_clk);
      n_cmp++;
      if (o_key_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b, expected 1", i, o_key_ready); end
      if (i >= 1) begin
        n_cmp++;
        if (o_fill !== 1) begin n_err++; $display("FAIL b2b_fill_%0d: got %0d, expected 1", i, o_fill); end
      end
      expect_key(i_key);
      step();
    end
    i_key_valid = 1'b0;
    wait_drain("b2b");
    n_cmp++;
    if (xfer_cnt - x0 !== 30) begin
      n_err++; $display("FAIL b2b_count: got %0d, expected 30", xfer_cnt - x0);
    end else begin
      n_cmp++;
      if (xcyc[$] - xcyc[xcyc.size() - 30] !== 29) begin
        n_err++; $display("FAIL b2b_rate: span %0d cycles, expected 29", xcyc[$] - xcyc[xcyc.size() - 30]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int x0;
    bit acc;
    i_byte_ready = 1'b1;
    offer(8'h82, acc);
    offer(8'h63, acc);
    step();
    #1;
    i_rst_n = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if (o_byte_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b, expected 0", o_byte_valid); end
    n_cmp++;
    if (o_fill !== '0) begin n_err++; $display("FAIL mid_rst_fill: got %0d, expected 0", o_fill); end
    n_cmp++;
    if (o_key_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b, expected 0", o_key_ready); end
    step();
    i_rst_n = 1'b1;
    step();
    x0 = xfer_cnt;
    offer(8'h62, acc);
    wait_drain("mid_rst");
    n_cmp++;
    if (xfer_cnt - x0 !== 1) begin n_err++; $display("FAIL mid_rst_count: got %0d bytes, expected 1", xfer_cnt - x0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_escape(8'h80);
    test_escape(8'h83);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
